// File: rtl/axis_pkt_arbiter.sv
// Packet-level AXI-Stream arbiter: round-robin grant per whole packet,
// mid-packet starvation watchdog with abort/drain, per-source statistics.
`timescale 1ns/1ps
module axis_pkt_arbiter #(
   parameter int NUM_SRC     = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   input  logic                          m_axis_tready,
   output logic [NUM_SRC-1:0]            grant_o,
   output logic                          busy_o,
   input  logic                          cnt_clr_i,
   output logic [NUM_SRC*CNT_WIDTH-1:0]  pkt_cnt_o,
   output logic [CNT_WIDTH-1:0]          abort_cnt_o
);

   // Handshake: a beat moves on a port when tvalid and tready are both high
   // at a rising clk edge; tvalid never depends on tready, and once m_axis_tvalid
   // is raised it stays up (with stable data) until the beat is taken.

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_ABORT, ST_DRAIN} state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       owner, owner_nxt;
   logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
   logic [WD_W-1:0]        wd_cnt, wd_nxt;
   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pkt_inc, abort_inc;
   logic                   sel_valid, sel_last;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [DATA_WIDTH-1:0]  src_data [NUM_SRC];
   logic [CNT_WIDTH-1:0]   pkt_cnt  [NUM_SRC];
   logic [CNT_WIDTH-1:0]   abort_cnt;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_SRC - 1) ? '0 : i + 1'b1;
   endfunction

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign pkt_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[i];
   end

   assign abort_cnt_o = abort_cnt;
   assign sel_valid   = s_axis_tvalid[owner];
   assign sel_last    = s_axis_tlast[owner];
   assign sel_data    = src_data[owner];
   assign busy_o      = (state != ST_IDLE);

   // Round-robin pick: first valid source at or above the pointer, with wrap.
   always_comb begin
      int cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         if (!pick_found && s_axis_tvalid[IDX_W'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   // One-hot owner while a packet is in flight (including abort/drain).
   always_comb begin
      grant_o = '0;
      if (state != ST_IDLE) grant_o[owner] = 1'b1;
   end

   // State, owner, pointer and watchdog registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         owner  <= '0;
         rr_ptr <= '0;
         wd_cnt <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         rr_ptr <= rr_ptr_nxt;
         wd_cnt <= wd_nxt;
      end
   end

   // Next-state logic and datapath muxing.
   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      rr_ptr_nxt    = rr_ptr;
      wd_nxt        = wd_cnt;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
      pkt_inc       = 1'b0;
      abort_inc     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               owner_nxt = pick_idx;
               wd_nxt    = '0;
               state_nxt = ST_PASS;
            end
         end
         ST_PASS: begin
            m_axis_tdata         = sel_data;
            m_axis_tvalid        = sel_valid;
            m_axis_tlast         = sel_last;
            s_axis_tready[owner] = m_axis_tready;
            if (sel_valid && m_axis_tready) begin
               // An accepted beat always beats a coincident timeout.
               wd_nxt = '0;
               if (sel_last) begin
                  state_nxt  = ST_IDLE;
                  rr_ptr_nxt = next_idx(owner);
                  pkt_inc    = 1'b1;
               end
            end else if (!sel_valid) begin
               // Only source starvation counts; downstream backpressure does not.
               if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                  wd_nxt    = '0;
                  state_nxt = ST_ABORT;
               end else begin
                  wd_nxt = wd_cnt + 1'b1;
               end
            end
         end
         ST_ABORT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            if (m_axis_tready) begin
               abort_inc = 1'b1;
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            s_axis_tready[owner] = 1'b1;
            if (sel_valid && sel_last) begin
               state_nxt  = ST_IDLE;
               rr_ptr_nxt = next_idx(owner);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Saturating statistics counters; clear has priority over increments.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) pkt_cnt[i] <= '0;
         abort_cnt <= '0;
      end else if (cnt_clr_i) begin
         for (int i = 0; i < NUM_SRC; i++) pkt_cnt[i] <= '0;
         abort_cnt <= '0;
      end else begin
         if (pkt_inc && (pkt_cnt[owner] != '1)) pkt_cnt[owner] <= pkt_cnt[owner] + 1'b1;
         if (abort_inc && (abort_cnt != '1)) abort_cnt <= abort_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-cycle vector table plus
// hand-written sequences for round-robin, reset and counter corners.
`timescale 1ns/1ps
module tb_axis_pkt_arbiter;

   localparam int NS = 2;
   localparam int DW = 8;
   localparam int TO = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   s_tdata;
   logic [1:0]    s_tvalid, s_tlast, s_tready;
   logic [7:0]    m_tdata;
   logic          m_tvalid, m_tlast, m_tuser, m_tready;
   logic [1:0]    grant;
   logic          busy, cnt_clr;
   logic [7:0]    pkt_cnt;
   logic [3:0]    abort_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       tag;
      logic [1:0]  vld;
      logic [1:0]  lst;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic        mrdy;
      logic [15:0] exp;
   } vec_t;

   vec_t       vec_q[$];
   logic [7:0] exp_q[$];

   axis_pkt_arbiter #(
      .NUM_SRC(NS), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
      .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
      .grant_o(grant), .busy_o(busy), .cnt_clr_i(cnt_clr),
      .pkt_cnt_o(pkt_cnt), .abort_cnt_o(abort_cnt)
   );

   // Clock.
   always #5 clk = ~clk;

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   function automatic logic [15:0] ex(logic mv, logic ml, logic mu, logic [7:0] md,
                                      logic [1:0] srdy, logic [1:0] gnt, logic bsy);
      return {mv, ml, mu, md, srdy, gnt, bsy};
   endfunction

   function automatic vec_t mk(string tag, logic [1:0] vld, logic [1:0] lst, logic [7:0] d0,
                               logic [7:0] d1, logic mrdy, logic [15:0] exp);
      vec_t v;
      v.tag = tag; v.vld = vld; v.lst = lst; v.d0 = d0; v.d1 = d1; v.mrdy = mrdy; v.exp = exp;
      return v;
   endfunction

   function automatic logic [15:0] out_vec();
      return {m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, grant, busy};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply queued vectors one per cycle: drive after posedge, check at negedge.
   task automatic run_table();
      foreach (vec_q[i]) begin
         s_tvalid = vec_q[i].vld;
         s_tlast  = vec_q[i].lst;
         s_tdata  = {vec_q[i].d1, vec_q[i].d0};
         m_tready = vec_q[i].mrdy;
         @(negedge clk);
         check($sformatf("%s[%0d]", vec_q[i].tag, i), 32'(out_vec()), 32'(vec_q[i].exp));
         @(posedge clk); #1;
      end
      vec_q.delete();
      s_tvalid = '0; s_tlast = '0; s_tdata = '0;
   endtask

   // Send an n-beat packet from one source with m_tready held high.
   task automatic send_pkt(input int src, input logic [7:0] d, input int n, input bit clr_last);
      for (int b = 0; b < n; b++) begin
         int guard;
         bit done;
         guard = 0;
         done  = 1'b0;
         s_tvalid = '0; s_tlast = '0;
         s_tvalid[src] = 1'b1;
         s_tlast[src]  = (b == n - 1);
         s_tdata[src*8 +: 8] = d + 8'(b);
         m_tready = 1'b1;
         cnt_clr  = clr_last && (b == n - 1);
         while (!done) begin
            @(negedge clk);
            if (s_tready[src]) begin
               done = 1'b1;
               check("sp_beat", 32'({m_tlast, m_tdata}), 32'({b == n - 1, d + 8'(b)}));
            end else begin
               guard++;
               if (guard > 20) begin
                  n_cmp++; n_bad++;
                  $display("FAIL sp_wait: no ready after %0d cycles, required ready", guard);
                  done = 1'b1;
               end
            end
            @(posedge clk); #1;
         end
      end
      s_tvalid = '0; s_tlast = '0; cnt_clr = 1'b0;
   endtask

   initial begin
      int beat [2];
      int pkt  [2];
      bit acc  [2];
      bit prev_last;
      logic [7:0] e;

      rst_n = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out", 32'(out_vec()), 32'h0);
      check("reset_cnt", 32'({pkt_cnt, abort_cnt}), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single 5-beat packet from source 0.
      vec_q.push_back(mk("t1_idle", 2'b01, 2'b00, 8'h11, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b00,2'b00,0)));
      for (int k = 0; k < 4; k++)
         vec_q.push_back(mk("t1_beat", 2'b01, 2'b00, 8'h11 + 8'(k), 8'h00, 1'b1,
                            ex(1,0,0,8'h11 + 8'(k),2'b01,2'b01,1)));
      vec_q.push_back(mk("t1_last", 2'b01, 2'b01, 8'h15, 8'h00, 1'b1, ex(1,1,0,8'h15,2'b01,2'b01,1)));
      vec_q.push_back(mk("t1_after", 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b00,2'b00,0)));
      run_table();
      check("t1_cnt", 32'(pkt_cnt), 32'h01);

      // Source 1 packet under downstream backpressure.
      vec_q.push_back(mk("bp_idle", 2'b10, 2'b00, 8'h00, 8'hA1, 1'b1, ex(0,0,0,8'h00,2'b00,2'b00,0)));
      vec_q.push_back(mk("bp_b1",   2'b10, 2'b00, 8'h00, 8'hA1, 1'b1, ex(1,0,0,8'hA1,2'b10,2'b10,1)));
      vec_q.push_back(mk("bp_s1",   2'b10, 2'b00, 8'h00, 8'hA2, 1'b0, ex(1,0,0,8'hA2,2'b00,2'b10,1)));
      vec_q.push_back(mk("bp_s2",   2'b10, 2'b00, 8'h00, 8'hA2, 1'b0, ex(1,0,0,8'hA2,2'b00,2'b10,1)));
      vec_q.push_back(mk("bp_b2",   2'b10, 2'b00, 8'h00, 8'hA2, 1'b1, ex(1,0,0,8'hA2,2'b10,2'b10,1)));
      vec_q.push_back(mk("bp_b3",   2'b10, 2'b00, 8'h00, 8'hA3, 1'b1, ex(1,0,0,8'hA3,2'b10,2'b10,1)));
      vec_q.push_back(mk("bp_s3",   2'b10, 2'b10, 8'h00, 8'hA4, 1'b0, ex(1,1,0,8'hA4,2'b00,2'b10,1)));
      vec_q.push_back(mk("bp_s4",   2'b10, 2'b10, 8'h00, 8'hA4, 1'b0, ex(1,1,0,8'hA4,2'b00,2'b10,1)));
      vec_q.push_back(mk("bp_b4",   2'b10, 2'b10, 8'h00, 8'hA4, 1'b1, ex(1,1,0,8'hA4,2'b10,2'b10,1)));
      vec_q.push_back(mk("bp_after", 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b00,2'b00,0)));
      run_table();
      check("bp_cnt", 32'({pkt_cnt, abort_cnt}), 32'h110);

      // Clear the counters while idle.
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      check("clr_idle", 32'(pkt_cnt), 32'h00);

      // Round robin: both sources offer four 3-beat packets back to back.
      for (int p = 0; p < 4; p++)
         for (int s = 0; s < 2; s++)
            for (int b = 0; b < 3; b++)
               exp_q.push_back(8'(s*128 + p*16 + b));
      beat[0] = 0; beat[1] = 0; pkt[0] = 0; pkt[1] = 0; prev_last = 1'b0;
      m_tready = 1'b1;
      for (int cyc = 0; cyc < 150 && exp_q.size() > 0; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = (pkt[i] < 4);
            s_tlast[i]  = (beat[i] == 2);
            s_tdata[i*8 +: 8] = 8'(i*128 + pkt[i]*16 + beat[i]);
         end
         @(negedge clk);
         if (prev_last) check("rr_gap", 32'({m_tvalid, busy}), 32'h0);
         prev_last = 1'b0;
         if (m_tvalid) begin
            e = exp_q.pop_front();
            check("rr_data", 32'({m_tlast, m_tuser, m_tdata}), 32'({e[3:0] == 4'd2, 1'b0, e}));
            prev_last = m_tlast;
         end
         for (int i = 0; i < 2; i++) acc[i] = s_tvalid[i] & s_tready[i];
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++)
            if (acc[i]) begin
               beat[i]++;
               if (beat[i] == 3) begin beat[i] = 0; pkt[i]++; end
            end
      end
      check("rr_left", 32'(exp_q.size()), 32'd0);
      s_tvalid = '0; s_tlast = '0; s_tdata = '0;
      check("rr_cnt", 32'(pkt_cnt), 32'h44);

      // Watchdog: 7 starved cycles are tolerated, the 8th aborts.
      vec_q.push_back(mk("ab_idle", 2'b01, 2'b00, 8'h21, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b00,2'b00,0)));
      vec_q.push_back(mk("ab_b1",   2'b01, 2'b00, 8'h21, 8'h00, 1'b1, ex(1,0,0,8'h21,2'b01,2'b01,1)));
      for (int k = 0; k < 7; k++)
         vec_q.push_back(mk("ab_gap7", 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b01,2'b01,1)));
      vec_q.push_back(mk("ab_b2",   2'b01, 2'b00, 8'h22, 8'h00, 1'b1, ex(1,0,0,8'h22,2'b01,2'b01,1)));
      for (int k = 0; k < 8; k++)
         vec_q.push_back(mk("ab_gap8", 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b01,2'b01,1)));
      vec_q.push_back(mk("ab_hold", 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, ex(1,1,1,8'h00,2'b00,2'b01,1)));
      vec_q.push_back(mk("ab_beat", 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, ex(1,1,1,8'h00,2'b00,2'b01,1)));
      vec_q.push_back(mk("dr_b3",   2'b01, 2'b00, 8'h23, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b01,2'b01,1)));
      vec_q.push_back(mk("dr_b4",   2'b01, 2'b00, 8'h24, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b01,2'b01,1)));
      vec_q.push_back(mk("dr_b5",   2'b01, 2'b01, 8'h25, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b01,2'b01,1)));
      vec_q.push_back(mk("dr_after", 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b00,2'b00,0)));
      vec_q.push_back(mk("nx_idle", 2'b01, 2'b01, 8'h31, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b00,2'b00,0)));
      vec_q.push_back(mk("nx_b1",   2'b01, 2'b01, 8'h31, 8'h00, 1'b1, ex(1,1,0,8'h31,2'b01,2'b01,1)));
      vec_q.push_back(mk("nx_after", 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, ex(0,0,0,8'h00,2'b00,2'b00,0)));
      run_table();
      check("ab_cnt", 32'({pkt_cnt, abort_cnt}), 32'h451);

      // Asynchronous reset in the middle of a packet.
      s_tvalid = 2'b01; s_tdata = 16'h0041; m_tready = 1'b1;
      @(posedge clk); #1;
      s_tdata = 16'h0042;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_pre", 32'({m_tvalid, m_tdata, grant}), 32'({1'b1, 8'h42, 2'b01}));
      #1 rst_n = 1'b0;
      #1;
      check("rst_out", 32'(out_vec()), 32'h0);
      check("rst_cnt", 32'({pkt_cnt, abort_cnt}), 32'h0);
      s_tvalid = '0; s_tdata = '0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      s_tvalid = 2'b10; s_tlast = 2'b10; s_tdata = 16'h5100;
      @(negedge clk);
      check("rst_idle", 32'(out_vec()), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_pkt", 32'(out_vec()), 32'(ex(1,1,0,8'h51,2'b10,2'b10,1)));
      @(posedge clk); #1;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0;
      @(negedge clk);
      check("rst_done", 32'({busy, pkt_cnt}), 32'h010);
      @(posedge clk); #1;

      // Saturation at all-ones, then clear against a coincident completion.
      for (int k = 0; k < 15; k++) send_pkt(0, 8'h60 + 8'(k), 1, 1'b0);
      check("sat_full", 32'(pkt_cnt[3:0]), 32'hF);
      send_pkt(0, 8'h80, 2, 1'b0);
      check("sat_hold", 32'(pkt_cnt[3:0]), 32'hF);
      send_pkt(1, 8'h70, 2, 1'b1);
      check("clr_wins", 32'({pkt_cnt, abort_cnt}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
Packet-level AXI-Stream arbiter that shares the single UDP TX payload path of the GMII/UDP transmit block between several requesters, e.g. the PTP frame generator (source 0) and the TSS controller (source 1).
- Grants one source for a whole packet and never interleaves beats of different packets.
- Uses round-robin fairness between sources.
- Guards the shared path with a mid-packet starvation watchdog that aborts a stalled packet and drains its remaining beats.
- Exposes per-source packet counters for firmware statistics.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- DATA_WIDTH, 8, AXI-Stream data width.
- TIMEOUT_CYC, 4096, consecutive mid-packet idle cycles before abort (≥2).
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock (GMII TX clock domain).
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data; source i occupies slice i.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  DATA_WIDTH  to UDP TX payload.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  1  1 = aborted/bad frame marker on the last beat.
- m_axis_tready  in  1  downstream ready.
- grant_o  out  NUM_SRC  one-hot current owner; 0 when idle.
- busy_o  out  1  high in any state other than IDLE.
- cnt_clr_i  in  1  synchronous clear of all counters.
- pkt_cnt_o  out  NUM_SRC*CNT_WIDTH  completed packets per source.
- abort_cnt_o  out  CNT_WIDTH  number of aborted packets.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: all s_axis_tready=0; m_axis_tvalid/tlast/tuser=0; m_axis_tdata=0; grant_o=0; busy_o=0.
  - Internal: state=IDLE; RR pointer=0; watchdog=0; all counters=0.
  - Reset mid-packet drops the packet silently; no abort beat is emitted.
- State machine: IDLE, PASS, ABORT, DRAIN.
- IDLE:
  - All s_axis_tready=0 and m_axis_tvalid=0.
  - When any s_axis_tvalid is high, pick the first asserted index searching from the RR pointer upward with wrap.
  - Register the pick into grant_o and go to PASS next cycle.
  - Latency: first beat can transfer 1 cycle after tvalid is first seen in IDLE.
- PASS (owner g):
  - Combinational passthrough: m_axis_tdata/tvalid/tlast = source g; m_axis_tuser=0; s_axis_tready[g]=m_axis_tready; all other readies 0.
  - On a beat with tvalid & tready & tlast:
    - go to IDLE next cycle;
    - RR pointer = (g+1) mod NUM_SRC;
    - pkt_cnt[g] increments, saturating at all-ones.
  - At least one IDLE cycle always separates packets.
- Watchdog, PASS only:
  - Counts cycles with s_axis_tvalid[g]=0; cleared on any accepted beat and on entry to PASS.
  - Cycles with tvalid=1 but m_axis_tready=0 do not count (downstream backpressure is never a timeout).
  - When the count reaches TIMEOUT_CYC, go to ABORT.
  - Simultaneous timeout and valid beat: the beat wins and the watchdog clears.
- ABORT:
  - Drive m_axis_tvalid=1, tlast=1, tuser=1, tdata=0; all s_axis_tready=0.
  - Hold until m_axis_tready=1, then go to DRAIN.
  - abort_cnt increments on that handshake, saturating.
- DRAIN:
  - s_axis_tready[g]=1; m_axis_tvalid=0; source beats are discarded.
  - On an accepted s tlast beat, go to IDLE with the RR pointer advanced past g.
  - No watchdog in DRAIN.
- Counters:
  - cnt_clr_i=1 zeroes all counters next cycle.
  - Clear wins over a coincident increment.
- AXI rules:
  - m_axis_tvalid never drops without a handshake, except at reset.
  - m_axis_tdata is stable while tvalid=1 and tready=0, provided the source obeys AXI.

Test Plan:
- Single source 0 sends a 5-beat packet 0x11..0x15, m_axis_tready=1 → grant_o=01 one cycle after tvalid; output beats 0x11..0x15 with tlast on 0x15; pkt_cnt[0]=1; busy_o low 1 cycle after the last beat.
- Both sources hold 3-beat packets continuously for 4 packets each → output order 0,1,0,1,0,1,0,1; no interleaving; 1 idle cycle between packets; pkt_cnt=4/4.
- Source 1 sends 4 beats while m_axis_tready toggles 1,0,0,1,… → data matches in order; no beat lost or duplicated; watchdog never fires.
- TIMEOUT_CYC=8; source 0 sends 2 beats, then drops tvalid for 8 cycles → one beat with tdata=0, tlast=1, tuser=1; abort_cnt=1; the later 3-beat remainder of that packet is consumed with no output; the next packet is then granted normally.
- rst_n pulsed low in PASS mid-packet → all outputs 0 immediately; counters 0; after release, a fresh packet from source 1 passes with grant_o=10.
- pkt_cnt[0] preloaded to 0xFFFF by traffic with CNT_WIDTH=16 → the next packet leaves it at 0xFFFF; cnt_clr_i pulsed on the same cycle as a packet completion → the counter reads 0.
